vram_scan_arbiter: RTL

- Shares one single-port synchronous video RAM between the display scanout and NWR game-logic writers.
- Scanout reads use the pixel strobe, active flag and x/y coordinates from the 640x480 timing generator.
- Scanout reads have absolute priority; writers fill all other clock cycles, granted round-robin.
- Outputs pixel data to the colour/DAC stage and per-frame write statistics for debug.

---
 rtl/vram_scan_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_scan_arbiter.sv
// -----------------------------------------------------------------------------
// vram_scan_arbiter
//
// Shares one single-port synchronous video RAM between the display scanout and
// NWR game-logic writers. A pixel-strobe cycle is a display slot and always
// owns the RAM. Every other cycle is offered to the writers, which are served
// round-robin. Read data returns to the DAC stage three cycles after the strobe.
// Blanking strobes produce a zero pixel with the same cadence. A per-frame count
// of completed writes is published for debug on every end-of-frame pulse.
//
// Build option:
//   VRAM_WR_BLANK_ONLY_EN  when defined, writers are only granted while
//                          i_active=0 (blanking), so no write can tear a visible
//                          frame. Requests made during active drawing wait with
//                          the round-robin pointer frozen.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_pix_stb           pixel strobe (one i_clk cycle wide)
//   i_active            timing generator active-drawing flag
//   i_screenend         one-tick end-of-frame pulse
//   i_x, i_y            current pixel coordinates
//   i_wr_req            per-writer write request (level)
//   i_wr_addr           packed writer addresses, writer k at [k*AW +: AW]
//   i_wr_data           packed writer data,      writer k at [k*DW +: DW]
//   o_wr_gnt            one-hot combinational grant
//   o_wr_oob            registered pulse: granted write was out of range
//   o_mem_addr/we/wdata registered RAM command
//   i_mem_rdata         RAM read data, one cycle after the address
//   o_pix_data/valid    pixel to the DAC stage and its one-cycle valid pulse
//   o_frame_wr_count    writes completed in the previous frame
// -----------------------------------------------------------------------------
module vram_scan_arbiter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int AW    = 19,
    parameter int DW    = 8,
    parameter int NWR   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_stb,
    input  logic              i_active,
    input  logic              i_screenend,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic [NWR-1:0]    i_wr_req,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic [NWR*DW-1:0] i_wr_data,
    output logic [NWR-1:0]    o_wr_gnt,
    output logic              o_wr_oob,
    output logic [AW-1:0]     o_mem_addr,
    output logic              o_mem_we,
    output logic [DW-1:0]     o_mem_wdata,
    input  logic [DW-1:0]     i_mem_rdata,
    output logic [DW-1:0]     o_pix_data,
    output logic              o_pix_valid,
    output logic [15:0]       o_frame_wr_count
);

    localparam int          LW        = (NWR > 1) ? $clog2(NWR) : 1;
    localparam logic [AW:0] PIX_TOTAL = (AW+1)'(H_RES * V_RES);

    // Writer k's position when searching 'ofs' places after 'base'.
    function automatic logic [LW-1:0] rr_idx(input logic [LW-1:0] base, input int ofs);
        int s;
        s = (int'(base) + ofs) % NWR;
        return LW'(s);
    endfunction

    logic [LW-1:0] last_q;        // most recently granted writer
    logic          writer_slot;   // this cycle may be given to a writer
    logic [NWR-1:0] gnt;
    logic          gnt_any;
    logic [LW-1:0] gnt_idx;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_in_range;
    logic          wr_done;       // an in-range write is accepted this cycle
    logic [AW-1:0] rd_addr;

    // Read pipeline: stage 1 holds the address cycle, stage 2 the data cycle.
    logic          rd1_v, rd1_blank;
    logic          rd2_v, rd2_blank;

    logic [15:0]   run_cnt;
    logic [15:0]   run_inc;

    // ------------------------------------------------------------------
    // Slot qualification. Reset also blocks grants so o_wr_gnt reads 0.
    // ------------------------------------------------------------------
`ifdef VRAM_WR_BLANK_ONLY_EN
    assign writer_slot = !i_rst && !i_pix_stb && !i_active;
`else
    assign writer_slot = !i_rst && !i_pix_stb;
`endif

    // ------------------------------------------------------------------
    // Round-robin search starting one past the last granted writer.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = last_q;
        for (int i = 1; i <= NWR; i++) begin
            if (writer_slot && !gnt_any && i_wr_req[rr_idx(last_q, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(last_q, i);
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign o_wr_gnt     = gnt;
    assign sel_addr     = i_wr_addr[gnt_idx*AW +: AW];
    assign sel_data     = i_wr_data[gnt_idx*DW +: DW];
    assign sel_in_range = {1'b0, sel_addr} < PIX_TOTAL;
    assign wr_done      = gnt_any && sel_in_range;

    // Linear framebuffer address, evaluated at AW bits.
    assign rd_addr = AW'(i_y) * AW'(H_RES) + AW'(i_x);

    // Saturating running-count increment.
    assign run_inc = (wr_done && run_cnt != 16'hFFFF) ? run_cnt + 16'd1 : run_cnt;

    // ------------------------------------------------------------------
    // RAM command register and round-robin pointer.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_wr_oob    <= 1'b0;
            last_q      <= LW'(NWR - 1);
        end else begin
            o_mem_we <= 1'b0;
            o_wr_oob <= 1'b0;
            if (i_pix_stb && i_active) begin
                o_mem_addr <= rd_addr;
            end else if (gnt_any) begin
                // The address and data are loaded even for an out-of-range
                // write; only the write enable is suppressed.
                o_mem_addr  <= sel_addr;
                o_mem_wdata <= sel_data;
                o_mem_we    <= sel_in_range;
                o_wr_oob    <= !sel_in_range;
                last_q      <= gnt_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scanout pipeline. Blank strobes travel the same stages so the output
    // cadence is identical whether or not the RAM was read.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: the data register is reset along with the valid bits because
        // its reset value is externally visible; clearing the valid bits is
        // what discards in-flight reads.
        if (i_rst) begin
            rd1_v       <= 1'b0;
            rd1_blank   <= 1'b0;
            rd2_v       <= 1'b0;
            rd2_blank   <= 1'b0;
            o_pix_valid <= 1'b0;
            o_pix_data  <= '0;
        end else begin
            rd1_v       <= i_pix_stb;
            rd1_blank   <= !i_active;
            rd2_v       <= rd1_v;
            rd2_blank   <= rd1_blank;
            o_pix_valid <= rd2_v;
            if (rd2_v) begin
                o_pix_data <= rd2_blank ? '0 : i_mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame write statistics. A grant coinciding with end-of-frame is
    // counted in the closing frame and also seeds the new frame's count.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_cnt          <= '0;
            o_frame_wr_count <= '0;
        end else if (i_screenend) begin
            o_frame_wr_count <= run_inc;
            run_cnt          <= wr_done ? 16'd1 : 16'd0;
        end else begin
            run_cnt <= run_inc;
        end
    end

endmodule
